aeolus_sequencer: RTL and testbench
===================================

# aeolus_sequencer

Multi-cycle control sequencer for the Aeolus 4-bit CPU. It owns the program counter and fetches 4-bit opcodes from the program ROM. For each instruction it issues exactly one single-cycle one-hot control strobe to the register file, ALU and accumulator datapath. It also resolves the conditional-skip instructions (SNZA/SNZS) from datapath flags. It replaces the free-running PC/incrementer so that ROMs with latency greater than zero and run/stop control can be supported.

## Interface
Parameters:
- PC_WIDTH, 4, program counter and ROM address width.
- ROM_LATENCY, 1, cycles from romAddr change to valid romData; legal range 1..4.

Ports:
- clk  in  1  system clock (divided CPU clock).
- reset  in  1  asynchronous, active-low reset.
- run  in  1  level; while high the sequencer executes instructions back to back.
- romAddr  out  PC_WIDTH  ROM address; equals pc.
- romData  in  4  opcode returned by ROM.
- aNonZero  in  1  datapath flag: A register non-zero (for SNZA).
- shiftFlag  in  1  datapath flag: shift flag (for SNZS).
- ctrl  out  16  one-hot instruction strobe, bit index = opcode.
- pc  out  PC_WIDTH  current program counter.
- busy  out  1  high in FETCH/EXEC.
- wrap  out  1  one-cycle pulse when pc wraps past 2^PC_WIDTH-1.
- step  in  1  single-step request (only with AEOLUS_SINGLE_STEP_EN).

## Operation
- Opcode map (ctrl bit): LDA 0, LDB 1, LDO 2, LDSA 3, LDSB 4, LSH 5, RSH 6, CLR 7, SNZA 8, SNZS 9, ADD 10, SUB 11, AND 12, OR 13, XOR 14, INV 15.
- States:
  - IDLE: ctrl=0, busy=0. Go to FETCH when run=1 is sampled high at a clock edge.
  - FETCH: romAddr=pc. A latency counter runs 0..ROM_LATENCY-1. On the last FETCH cycle, the instruction register IR is loaded from romData and the state goes to EXEC.
  - EXEC: exactly one cycle, ctrl=1<<IR. At the end of the cycle pc is updated and the state goes to FETCH if run=1, else IDLE.
- PC update:
  - Default is pc+1.
  - SNZA with aNonZero=1, or SNZS with shiftFlag=1: pc+2 (skip next instruction).
  - Flags are sampled at the edge ending EXEC.
  - Arithmetic is modulo 2^PC_WIDTH.
- SNZA/SNZS still drive their ctrl bit in EXEC so the datapath can route ALU inputs.
- wrap=1 for the cycle after any pc update whose unwrapped sum is at least 2^PC_WIDTH, e.g. 15+1 or 15+2, or 14+2 at PC_WIDTH=4.
- run falling during FETCH does not abort: the instruction completes its EXEC, then the sequencer goes to IDLE. pc holds, and resume continues from pc.
- No halt opcode; the program loops via wrap.

## Timing
- Reset values: pc=0, romAddr=0, ctrl=0, busy=0, wrap=0, IR=0, state=IDLE, latency counter=0.
- Reset asserts asynchronously at any time, including mid-EXEC, and clears all outputs immediately. Deassertion is sampled synchronously.
- ctrl, busy and wrap decode from registered state only; they are glitch-free with no combinational path from inputs.
- Instruction period is ROM_LATENCY+1 cycles. First EXEC occurs ROM_LATENCY+1 cycles after the edge that samples run=1 in IDLE.
- Back-to-back: FETCH of instruction n+1 starts the cycle after EXEC n, using the updated pc.

## Configuration
- AEOLUS_SINGLE_STEP_EN defined:
  - Adds the step port.
  - In IDLE, step=1 sampled at an edge runs exactly one FETCH+EXEC and then returns to IDLE regardless of run.
  - step is ignored outside IDLE.
  - run behaves as without the macro.
- AEOLUS_SINGLE_STEP_EN undefined: no step port; the sequencer leaves IDLE only via run.

## Test plan
- Reset with run=1 held: all outputs 0. Release reset, ROM[0]=LDA: FETCH on cycle 1, ctrl=0x0001 on cycle 2, pc=1 on cycle 3.
- ROM[0..2]=LDA,LDB,ADD, ROM_LATENCY=1: ctrl=0x0001, 0x0002, 0x0400 in EXEC cycles 2, 4, 6; pc goes 0→1→2→3. With ROM_LATENCY=3 the same sequence appears on cycles 4, 8, 12.
- ROM[3]=SNZA with aNonZero=1: ctrl=0x0100 and pc 3→5. Repeat with aNonZero=0: pc 3→4.
- ROM[15]=SNZS with shiftFlag=1: pc 15→1 and wrap pulses 1 cycle. ROM[15]=OR: pc 15→0 and wrap pulses; no wrap pulse on any other update.
- Drop run in the FETCH of pc=6: EXEC for opcode at 6 occurs, then busy=0 and pc=7 holds for 10 cycles. Raise run: next EXEC uses ROM[7].
- Assert reset mid-EXEC: ctrl=0 and pc=0 before the next edge. With AEOLUS_SINGLE_STEP_EN and run=0, a step pulse yields exactly one EXEC cycle, then IDLE.

Source files
------------

// File: rtl/aeolus_sequencer.sv
// Multi-cycle control sequencer for the Aeolus 4-bit CPU: PC, ROM fetch with latency, one-hot strobes.
// Optional macro AEOLUS_SINGLE_STEP_EN adds a step port that runs a single instruction from IDLE.
module aeolus_sequencer #(
    parameter int PC_WIDTH    = 4,
    parameter int ROM_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    output logic [PC_WIDTH-1:0] romAddr,
    input  logic [3:0]          romData,
    input  logic                aNonZero,
    input  logic                shiftFlag,
    output logic [15:0]         ctrl,
    output logic [PC_WIDTH-1:0] pc,
    output logic                busy,
    output logic                wrap
`ifdef AEOLUS_SINGLE_STEP_EN
    ,
    input  logic                step
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_e;

    localparam logic [3:0] OP_SNZA  = 4'd8;
    localparam logic [3:0] OP_SNZS  = 4'd9;
    localparam logic [1:0] LAT_LAST = 2'(ROM_LATENCY - 1);

    state_e              state_q, state_d;
    logic [1:0]          lat_q, lat_d;
    logic [3:0]          ir_q, ir_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                wrap_q, wrap_d;
    logic                skip;
    logic [PC_WIDTH:0]   pc_sum;
`ifdef AEOLUS_SINGLE_STEP_EN
    logic                single_q, single_d;
`endif

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        ir_d    = ir_q;
        pc_d    = pc_q;
        wrap_d  = 1'b0;
`ifdef AEOLUS_SINGLE_STEP_EN
        single_d = single_q;
`endif
        skip   = (ir_q == OP_SNZA && aNonZero) || (ir_q == OP_SNZS && shiftFlag);
        pc_sum = {1'b0, pc_q} + (skip ? (PC_WIDTH+1)'(2) : (PC_WIDTH+1)'(1));

        case (state_q)
            S_IDLE: begin
                lat_d = '0;
`ifdef AEOLUS_SINGLE_STEP_EN
                if (step) begin
                    state_d  = S_FETCH;
                    single_d = 1'b1;
                end else if (run) begin
                    state_d  = S_FETCH;
                    single_d = 1'b0;
                end
`else
                if (run) state_d = S_FETCH;
`endif
            end
            S_FETCH: begin
                if (lat_q == LAT_LAST) begin
                    ir_d    = romData;
                    lat_d   = '0;
                    state_d = S_EXEC;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            S_EXEC: begin
                // The carry out of the PC adder is the wrap indication.
                pc_d   = pc_sum[PC_WIDTH-1:0];
                wrap_d = pc_sum[PC_WIDTH];
`ifdef AEOLUS_SINGLE_STEP_EN
                state_d = (run && !single_q) ? S_FETCH : S_IDLE;
`else
                state_d = run ? S_FETCH : S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            lat_q   <= '0;
            ir_q    <= '0;
            pc_q    <= '0;
            wrap_q  <= 1'b0;
`ifdef AEOLUS_SINGLE_STEP_EN
            single_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            wrap_q  <= wrap_d;
`ifdef AEOLUS_SINGLE_STEP_EN
            single_q <= single_d;
`endif
        end
    end

    // NOTE: outputs decode only registered state, so they never glitch on input changes.
    assign ctrl    = (state_q == S_EXEC) ? (16'h0001 << ir_q) : 16'h0000;
    assign busy    = (state_q != S_IDLE);
    assign wrap    = wrap_q;
    assign pc      = pc_q;
    assign romAddr = pc_q;

endmodule

// File: tb/tb_aeolus_sequencer.sv
// Self-checking bench for aeolus_sequencer: instruction-schedule model plus directed literal checks.
module tb_aeolus_sequencer;

    localparam int PW   = 4;
    localparam int LAT  = 3;
    localparam int HALF = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0;
    logic          aNonZero = 1'b0;
    logic          shiftFlag = 1'b0;
    logic          step = 1'b0;
    logic [PW-1:0] romAddr, pc;
    logic [3:0]    romData;
    logic [15:0]   ctrl;
    logic          busy, wrap;

    logic [3:0]    rom [16];
    logic [PW-1:0] ap0, ap1;

    int  vectors = 0;
    int  miscompares = 0;
    bit  cmp_en = 1'b0;

    always #HALF clk = ~clk;

    // ROM with LAT cycles from address change to valid data.
    always @(posedge clk) begin
        ap0 <= romAddr;
        ap1 <= ap0;
    end
    assign romData = rom[ap1];

    aeolus_sequencer #(.PC_WIDTH(PW), .ROM_LATENCY(LAT)) dut (
        .clk(clk),
        .reset(rst_n),
        .run(run),
        .romAddr(romAddr),
        .romData(romData),
        .aNonZero(aNonZero),
        .shiftFlag(shiftFlag),
        .ctrl(ctrl),
        .pc(pc),
        .busy(busy),
        .wrap(wrap)
`ifdef AEOLUS_SINGLE_STEP_EN
        ,
        .step(step)
`endif
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Model: an instruction occupies LAT+1 cycles; its final cycle strobes rom[pc].
    int m_pc = 0;
    int m_phase = -1;
    bit m_wrap = 1'b0;
    bit m_single = 1'b0;
    int m_op, m_sum;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 0; m_phase = -1; m_wrap = 1'b0; m_single = 1'b0;
        end else begin
            m_wrap = 1'b0;
            if (m_phase < 0) begin
`ifdef AEOLUS_SINGLE_STEP_EN
                if (step) begin m_phase = 0; m_single = 1'b1; end else
`endif
                if (run) begin m_phase = 0; m_single = 1'b0; end
            end else if (m_phase < LAT) begin
                m_phase++;
            end else begin
                m_op   = int'(rom[m_pc]);
                m_sum  = m_pc + (((m_op == 8 && aNonZero) || (m_op == 9 && shiftFlag)) ? 2 : 1);
                m_wrap = (m_sum >= 16);
                m_pc   = m_sum % 16;
                m_phase = (run && !m_single) ? 0 : -1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("ctrl", 32'(ctrl), (m_phase == LAT) ? 32'(16'h0001 << rom[m_pc]) : 32'h0);
            check("pc", 32'(pc), 32'(m_pc));
            check("romAddr", 32'(romAddr), 32'(m_pc));
            check("busy", 32'(busy), 32'(m_phase >= 0));
            check("wrap", 32'(wrap), 32'(m_wrap));
        end
    end

    task automatic wait_exec(input string nm, input logic [PW-1:0] want_pc,
                             input logic [15:0] want_ctrl, input int budget);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            found = (pc == want_pc) && (ctrl == want_ctrl);
        end
        check(nm, 32'(found), 32'h1);
    endtask

    task automatic first_run(input logic anz, input logic [PW-1:0] exp_pc);
        aNonZero = anz;
        run = 1'b1;
        @(negedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_ctrl", 32'(ctrl), 32'h0);
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_wrap", 32'(wrap), 32'h0);
        #1 rst_n = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            case (c)
                1:  check("c1_busy", 32'(busy), 32'h1);
                4:  check("c4_ctrl", 32'(ctrl), 32'h0001);
                5:  check("c5_pc", 32'(pc), 32'h1);
                8:  check("c8_ctrl", 32'(ctrl), 32'h0002);
                12: check("c12_ctrl", 32'(ctrl), 32'h0400);
                13: check("c13_pc", 32'(pc), 32'h3);
                16: check("c16_snza", 32'(ctrl), 32'h0100);
                17: check("c17_pc", 32'(pc), 32'(exp_pc));
                default: ;
            endcase
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 4'd7;
        rom[0] = 4'd0; rom[1] = 4'd1; rom[2] = 4'd10; rom[3] = 4'd8;
        rom[6] = 4'd12; rom[7] = 4'd14; rom[15] = 4'd9;
        run = 1'b1;
        @(negedge clk);
        cmp_en = 1'b1;

        first_run(1'b1, 4'd5);
        first_run(1'b0, 4'd4);

        // SNZS at the top of memory skips across the wrap.
        aNonZero = 1'b0;
        shiftFlag = 1'b1;
        wait_exec("reach_snzs", 4'd15, 16'h0200, 100);
        @(negedge clk);
        check("snzs_pc", 32'(pc), 32'h1);
        check("snzs_wrap", 32'(wrap), 32'h1);
        @(negedge clk);
        check("wrap_pulse_end", 32'(wrap), 32'h0);

        rom[15] = 4'd13;
        wait_exec("reach_or", 4'd15, 16'h2000, 100);
        @(negedge clk);
        check("or_pc", 32'(pc), 32'h0);
        check("or_wrap", 32'(wrap), 32'h1);

        // Drop run during the fetch of pc=6.
        wait_exec("fetch6", 4'd6, 16'h0000, 100);
        run = 1'b0;
        wait_exec("exec6", 4'd6, 16'h1000, 10);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_busy", 32'(busy), 32'h0);
            check("hold_pc", 32'(pc), 32'h7);
        end
        run = 1'b1;
        wait_exec("resume7", 4'd7, 16'h4000, LAT + 3);

        // Asynchronous reset in the middle of EXEC.
        #1 rst_n = 1'b0;
        #1;
        check("async_ctrl", 32'(ctrl), 32'h0);
        check("async_pc", 32'(pc), 32'h0);
        check("async_busy", 32'(busy), 32'h0);
        run = 1'b0;
        @(negedge clk); #1 rst_n = 1'b1;

`ifdef AEOLUS_SINGLE_STEP_EN
        begin
            int n_exec;
            n_exec = 0;
            repeat (3) @(negedge clk);
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            for (int i = 0; i < 12; i++) begin
                if (ctrl != 16'h0) n_exec++;
                @(negedge clk);
            end
            check("step_exec_count", 32'(n_exec), 32'h1);
            check("step_idle", 32'(busy), 32'h0);
            check("step_pc", 32'(pc), 32'h1);
        end
`endif

        // Randomised phase: random ROM, flags, run toggles and rare async resets.
        for (int r = 0; r < 4; r++) begin
            @(negedge clk); #1 rst_n = 1'b0;
            for (int i = 0; i < 16; i++) rom[i] = 4'($urandom_range(0, 15));
            run = 1'b1;
            @(negedge clk); #1 rst_n = 1'b1;
            for (int c = 0; c < 2000; c++) begin
                @(negedge clk);
                aNonZero  = 1'($urandom);
                shiftFlag = 1'($urandom);
                if ($urandom_range(0, 15) == 0) run = ~run;
                if ($urandom_range(0, 499) == 0) begin
                    #1 rst_n = 1'b0;
                    #2 rst_n = 1'b1;
                end
            end
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
